// File: rtl/mat_feeder.sv
// 4x4 matrix sequencer for the 4-element dot-product unit: loads A and B, issues
// 16 row/column pairs, captures results and streams C. Optional: MAT_FEEDER_KEEP_B_EN.
module mat_feeder #(
    parameter int          WIDTH_A_80  = 9,
    parameter int          WIDTH_B_80  = 8,
    parameter int          WIDTH_SUM   = 11,
    parameter int unsigned DOT_LATENCY = 1
) (
    input  logic                  clk_80,
    input  logic                  rst_80,
    input  logic                  in_valid_80,
    output logic                  in_ready_80,
    input  logic [WIDTH_A_80-1:0] in_data_80,
    output logic [WIDTH_A_80-1:0] dot_a0_80,
    output logic [WIDTH_A_80-1:0] dot_a1_80,
    output logic [WIDTH_A_80-1:0] dot_a2_80,
    output logic [WIDTH_A_80-1:0] dot_a3_80,
    output logic [WIDTH_B_80-1:0] dot_b0_80,
    output logic [WIDTH_B_80-1:0] dot_b1_80,
    output logic [WIDTH_B_80-1:0] dot_b2_80,
    output logic [WIDTH_B_80-1:0] dot_b3_80,
    input  logic [WIDTH_SUM-1:0]  dot_result_80,
    output logic                  out_valid_80,
    input  logic                  out_ready_80,
    output logic [WIDTH_SUM-1:0]  out_data_80,
    output logic                  out_last_80,
    output logic                  busy_80
);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, OUTPUT} state_t;

    state_t                state;
    logic [3:0]            k;
    logic [3:0]            m;
    logic [4:0]            iss;
    logic                  done;
    logic                  issue_v;
    logic [3:0]            issue_n;
    logic [DOT_LATENCY-1:0] sr_v;
    logic [3:0]            sr_n [DOT_LATENCY];
`ifdef MAT_FEEDER_KEEP_B_EN
    logic                  b_loaded;
`endif

    logic [WIDTH_A_80-1:0] a_mem [16];
    logic [WIDTH_B_80-1:0] b_mem [16];
    logic [WIDTH_SUM-1:0]  c_mem [16];

    logic       load_xfer;
    logic       load_last;
    logic       enter_compute;
    logic       issue_now;
    logic [3:0] issue_idx;

    always_comb begin
        load_xfer     = in_valid_80 && in_ready_80;
        load_last     = load_xfer && (k == 4'd15);
        enter_compute = (state == LOAD_B) && load_last;
`ifdef MAT_FEEDER_KEEP_B_EN
        enter_compute = enter_compute || ((state == LOAD_A) && load_last && b_loaded);
`endif
        // pair 0 goes out on the same edge that enters COMPUTE
        issue_now = enter_compute || ((state == COMPUTE) && !iss[4]);
        issue_idx = enter_compute ? 4'd0 : iss[3:0];
    end

    always_ff @(posedge clk_80) begin
        if (!rst_80) begin
            if (load_xfer && (state == LOAD_A)) a_mem[k] <= in_data_80;
            if (load_xfer && (state == LOAD_B)) b_mem[k] <= in_data_80[WIDTH_B_80-1:0];
            if (sr_v[DOT_LATENCY-1]) c_mem[sr_n[DOT_LATENCY-1]] <= dot_result_80;
        end
    end

    always_ff @(posedge clk_80) begin
        if (rst_80) begin
            state        <= LOAD_A;
            k            <= '0;
            m            <= '0;
            iss          <= '0;
            done         <= 1'b0;
            issue_v      <= 1'b0;
            issue_n      <= '0;
            sr_v         <= '0;
            for (int unsigned i = 0; i < DOT_LATENCY; i++) sr_n[i] <= '0;
`ifdef MAT_FEEDER_KEEP_B_EN
            b_loaded     <= 1'b0;
`endif
            in_ready_80  <= 1'b1;
            out_valid_80 <= 1'b0;
            out_last_80  <= 1'b0;
            out_data_80  <= '0;
            busy_80      <= 1'b0;
            dot_a0_80    <= '0;
            dot_a1_80    <= '0;
            dot_a2_80    <= '0;
            dot_a3_80    <= '0;
            dot_b0_80    <= '0;
            dot_b1_80    <= '0;
            dot_b2_80    <= '0;
            dot_b3_80    <= '0;
        end else begin
            // result tag pipeline, aligned with the dot unit's register stages
            sr_v[0] <= issue_v;
            sr_n[0] <= issue_n;
            for (int unsigned i = 1; i < DOT_LATENCY; i++) begin
                sr_v[i] <= sr_v[i-1];
                sr_n[i] <= sr_n[i-1];
            end
            issue_v <= issue_now;
            if (sr_v[DOT_LATENCY-1] && (sr_n[DOT_LATENCY-1] == 4'd15)) done <= 1'b1;

            if (issue_now) begin
                issue_n   <= issue_idx;
                iss       <= {1'b0, issue_idx} + 5'd1;
                dot_a0_80 <= a_mem[{issue_idx[3:2], 2'd0}];
                dot_a1_80 <= a_mem[{issue_idx[3:2], 2'd1}];
                dot_a2_80 <= a_mem[{issue_idx[3:2], 2'd2}];
                dot_a3_80 <= a_mem[{issue_idx[3:2], 2'd3}];
                dot_b0_80 <= b_mem[{2'd0, issue_idx[1:0]}];
                dot_b1_80 <= b_mem[{2'd1, issue_idx[1:0]}];
                dot_b2_80 <= b_mem[{2'd2, issue_idx[1:0]}];
                dot_b3_80 <= b_mem[{2'd3, issue_idx[1:0]}];
            end

            case (state)
                LOAD_A, LOAD_B: begin
                    if (load_xfer) k <= k + 4'd1;
                    if (enter_compute) begin
                        state       <= COMPUTE;
                        in_ready_80 <= 1'b0;
                        busy_80     <= 1'b1;
`ifdef MAT_FEEDER_KEEP_B_EN
                        b_loaded    <= 1'b1;
`endif
                    end else if (load_last) begin
                        state <= LOAD_B;
                    end
                end
                COMPUTE: begin
                    if (done) begin
                        state        <= OUTPUT;
                        done         <= 1'b0;
                        m            <= '0;
                        out_valid_80 <= 1'b1;
                        out_data_80  <= c_mem[0];
                        out_last_80  <= 1'b0;
                        dot_a0_80    <= '0;
                        dot_a1_80    <= '0;
                        dot_a2_80    <= '0;
                        dot_a3_80    <= '0;
                        dot_b0_80    <= '0;
                        dot_b1_80    <= '0;
                        dot_b2_80    <= '0;
                        dot_b3_80    <= '0;
                    end
                end
                OUTPUT: begin
                    if (out_ready_80) begin
                        if (m == 4'd15) begin
                            state        <= LOAD_A;
                            m            <= '0;
                            out_valid_80 <= 1'b0;
                            out_last_80  <= 1'b0;
                            out_data_80  <= '0;
                            in_ready_80  <= 1'b1;
                            busy_80      <= 1'b0;
                        end else begin
                            m           <= m + 4'd1;
                            out_data_80 <= c_mem[m + 4'd1];
                            out_last_80 <= (m == 4'd14);
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule
